mdu_seq: RTL and testbench

MDU_SEQ -- requirements
Module: mdu_seq

---
 rtl/mdu_seq.sv | 151 +++++++++++++++
 tb/tb_mdu_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - sequential multiply/divide unit with architectural HI/LO registers
//
// Purpose: issues mult/multu/div/divu with a fixed busy latency, commits the
// result to HI/LO at the end of the busy window, and handles mthi/mtlo in one
// edge. A pipeline flush (cancel) discards any in-flight result.
//
// Ports:
//   clk     - single clock, all state on the rising edge
//   reset   - asynchronous active-low reset
//   start   - request to issue op this cycle
//   op      - 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 11x reserved
//   a, b    - source operands (rs, rt); mthi/mtlo use a only
//   cancel  - exception flush from pipeline control
//   busy    - registered, high while a mult/div is in flight
//   done    - registered, one-cycle pulse after a mult/div commits
//   hi, lo  - architectural HI/LO registers
module mdu_seq #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [31:0] tmp_hi;
  logic [31:0] tmp_lo;
  logic        tmp_wr;   // cleared for divide-by-zero so the commit leaves HI/LO alone

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] sdivisor;
  logic [31:0] udivisor;
  logic [31:0] sq_mag;
  logic [31:0] sr_mag;
  logic [31:0] sq;
  logic [31:0] sr;
  logic [31:0] uq;
  logic [31:0] ur;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed division is done on magnitudes so 0x80000000 / -1 falls out as
  // 0x80000000 rem 0 without relying on signed-overflow semantics.
  assign abs_a    = a[31] ? (~a + 32'd1) : a;
  assign abs_b    = b[31] ? (~b + 32'd1) : b;
  // A zero divisor is replaced by 1 only to keep the divider defined; the
  // result is never committed in that case.
  assign sdivisor = (b == 32'd0) ? 32'd1 : abs_b;
  assign udivisor = (b == 32'd0) ? 32'd1 : b;
  assign sq_mag   = abs_a / sdivisor;
  assign sr_mag   = abs_a % sdivisor;
  assign sq       = (a[31] ^ b[31]) ? (~sq_mag + 32'd1) : sq_mag;
  assign sr       = a[31] ? (~sr_mag + 32'd1) : sr_mag;
  assign uq       = a / udivisor;
  assign ur       = a % udivisor;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= 5'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      tmp_hi <= 32'd0;
      tmp_lo <= 32'd0;
      tmp_wr <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !cancel) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                {tmp_hi, tmp_lo} <= (op == OP_MULT) ? prod_s : prod_u;
                tmp_wr <= 1'b1;
                cnt    <= MULT_N;
                busy   <= 1'b1;
                state  <= S_MUL;
              end
              OP_DIV, OP_DIVU: begin
                tmp_lo <= (op == OP_DIV) ? sq : uq;
                tmp_hi <= (op == OP_DIV) ? sr : ur;
                tmp_wr <= (b != 32'd0);
                cnt    <= DIV_N;
                busy   <= 1'b1;
                state  <= S_DIV;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          if (cancel) begin
            // Flush wins even over a commit on this same edge.
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= 5'd0;
          end else if (cnt == 5'd1) begin
            if (tmp_wr) begin
              hi <= tmp_hi;
              lo <= tmp_lo;
            end
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cnt   <= 5'd0;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          cnt   <= 5'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - self-checking bench for mdu_seq with a reference model
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_seq #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Architectural behaviour in plain 64-bit arithmetic.
  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                inout logic [31:0] mh, inout logic [31:0] ml);
    longint          sp, sx, sy, q, r;
    longint unsigned up;
    int unsigned     uq, ur;
    case (o)
      3'd0: begin
        sp = longint'(int'(x)) * longint'(int'(y));
        mh = sp[63:32]; ml = sp[31:0];
      end
      3'd1: begin
        up = longint'({32'd0, x}) * longint'({32'd0, y});
        mh = up[63:32]; ml = up[31:0];
      end
      3'd2: if (y != 0) begin
        sx = longint'(int'(x)); sy = longint'(int'(y));
        q = sx / sy; r = sx % sy;
        ml = q[31:0]; mh = r[31:0];
      end
      3'd3: if (y != 0) begin
        uq = x / y; ur = x % y;
        ml = uq; mh = ur;
      end
      3'd4: mh = x;
      3'd5: ml = x;
      default: ;
    endcase
  endfunction

  function automatic int cycles_of(input logic [2:0] o);
    if (o == 3'd0 || o == 3'd1) return 5;
    if (o == 3'd2 || o == 3'd3) return 10;
    return 0;
  endfunction

  // Drives one op and returns how many sampled cycles busy stayed high and the
  // done value in the cycle busy fell (bounded at 64 cycles).
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int bc, output logic dn);
    start = 1'b1; op = o; a = x; b = y;
    step;
    start = 1'b0;
    bc = 0;
    while (busy === 1'b1 && bc < 64) begin
      bc++;
      step;
    end
    dn = done;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; cancel = 1'b0;
    step; step;
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_ctrl busy=%b done=%b want 0 0", busy, done); end
    tests++; if (hi !== 32'd0 || lo !== 32'd0) begin fails++; $display("FAIL reset_hilo hi=%h lo=%h want 0 0", hi, lo); end
    reset = 1'b1;
    step;
  endtask

  task automatic test_mult;
    int bc; logic dn;
    do_op(3'd0, 32'hFFFFFFFF, 32'h00000002, bc, dn);
    tests++; if (bc !== 5 || dn !== 1'b1) begin fails++; $display("FAIL mult_timing busy_cycles=%0d done=%b want 5 1", bc, dn); end
    tests++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE) begin fails++; $display("FAIL mult_result hi=%h lo=%h want ffffffff fffffffe", hi, lo); end
    step;
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL mult_done_pulse done=%b want 0", done); end
    do_op(3'd1, 32'hFFFFFFFF, 32'h00000002, bc, dn);
    tests++; if (bc !== 5 || dn !== 1'b1) begin fails++; $display("FAIL multu_timing busy_cycles=%0d done=%b want 5 1", bc, dn); end
    tests++; if (hi !== 32'h00000001 || lo !== 32'hFFFFFFFE) begin fails++; $display("FAIL multu_result hi=%h lo=%h want 00000001 fffffffe", hi, lo); end
    m_hi = 32'h00000001; m_lo = 32'hFFFFFFFE;
  endtask

  task automatic test_div;
    int bc; logic dn;
    do_op(3'd2, 32'hFFFFFFF9, 32'd2, bc, dn);
    tests++; if (bc !== 10 || dn !== 1'b1) begin fails++; $display("FAIL div_timing busy_cycles=%0d done=%b want 10 1", bc, dn); end
    tests++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_result hi=%h lo=%h want ffffffff fffffffd", hi, lo); end
    do_op(3'd3, 32'd7, 32'd0, bc, dn);
    tests++; if (bc !== 10 || dn !== 1'b1) begin fails++; $display("FAIL divz_timing busy_cycles=%0d done=%b want 10 1", bc, dn); end
    tests++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin fails++; $display("FAIL divz_unchanged hi=%h lo=%h want ffffffff fffffffd", hi, lo); end
    do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, bc, dn);
    tests++; if (hi !== 32'h00000000 || lo !== 32'h80000000) begin fails++; $display("FAIL div_ovf hi=%h lo=%h want 00000000 80000000", hi, lo); end
    m_hi = 32'h00000000; m_lo = 32'h80000000;
  endtask

  task automatic test_random;
    int bc; logic dn; logic [2:0] o; logic [31:0] x, y;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin x = 32'h80000000; y = 32'hFFFFFFFF; end
      model(o, x, y, m_hi, m_lo);
      do_op(o, x, y, bc, dn);
      tests++;
      if (bc !== cycles_of(o) || dn !== (cycles_of(o) != 0) || hi !== m_hi || lo !== m_lo) begin
        fails++;
        $display("FAIL rand_op%0d op=%0d a=%h b=%h busy_cycles=%0d done=%b hi=%h lo=%h want %0d %b %h %h",
                 i, o, x, y, bc, dn, hi, lo, cycles_of(o), cycles_of(o) != 0, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_cancel;
    int bc; logic dn;
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
    step;
    start = 1'b0;
    step; step; step;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL cancel_pre busy=%b want 1", busy); end
    cancel = 1'b1;
    step;
    cancel = 1'b0;
    tests++; if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin fails++; $display("FAIL cancel_div busy=%b done=%b hi=%h lo=%h want 0 0 %h %h", busy, done, hi, lo, m_hi, m_lo); end
    do_op(3'd4, 32'h12345678, 32'd0, bc, dn);
    m_hi = 32'h12345678;
    tests++; if (hi !== 32'h12345678 || lo !== m_lo || bc !== 0 || dn !== 1'b0) begin fails++; $display("FAIL mthi hi=%h lo=%h busy_cycles=%0d done=%b want 12345678 %h 0 0", hi, lo, bc, dn, m_lo); end
    // Cancel on the commit edge discards the result.
    start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
    step;
    start = 1'b0;
    step; step; step; step;
    cancel = 1'b1;
    step;
    cancel = 1'b0;
    tests++; if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin fails++; $display("FAIL cancel_commit busy=%b done=%b hi=%h lo=%h want 0 0 %h %h", busy, done, hi, lo, m_hi, m_lo); end
    // Cancel with start in IDLE blocks mtlo and mult alike.
    start = 1'b1; cancel = 1'b1; op = 3'd5; a = 32'hDEADBEEF;
    step;
    op = 3'd0;
    step;
    start = 1'b0; cancel = 1'b0;
    tests++; if (busy !== 1'b0 || lo !== m_lo || hi !== m_hi) begin fails++; $display("FAIL cancel_idle busy=%b hi=%h lo=%h want 0 %h %h", busy, hi, lo, m_hi, m_lo); end
  endtask

  task automatic test_start_while_busy;
    int bc;
    start = 1'b1; op = 3'd1; a = 32'd6; b = 32'd7;
    step;
    op = 3'd5; a = 32'hCAFEF00D;
    step; step;
    start = 1'b0;
    bc = 2;
    while (busy === 1'b1 && bc < 64) begin bc++; step; end
    model(3'd1, 32'd6, 32'd7, m_hi, m_lo);
    tests++; if (bc !== 5 || done !== 1'b1 || hi !== m_hi || lo !== m_lo) begin fails++; $display("FAIL start_busy busy_cycles=%0d done=%b hi=%h lo=%h want 5 1 %h %h", bc, done, hi, lo, m_hi, m_lo); end
  endtask

  task automatic test_reset_mid;
    int seen;
    start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
    step;
    start = 1'b0;
    step; step;
    #2 reset = 1'b0;
    #1;
    tests++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin fails++; $display("FAIL reset_async busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo); end
    step;
    reset = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step;
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    tests++; if (seen !== 0 || hi !== 32'd0 || lo !== 32'd0) begin fails++; $display("FAIL reset_abort bad_cycles=%0d hi=%h lo=%h want 0 0 0", seen, hi, lo); end
  endtask

  task automatic test_back_to_back;
    int bc; logic dn;
    do_op(3'd0, 32'hFFFFFFF0, 32'd3, bc, dn);
    model(3'd0, 32'hFFFFFFF0, 32'd3, m_hi, m_lo);
    tests++; if (bc !== 5 || dn !== 1'b1 || hi !== m_hi || lo !== m_lo) begin fails++; $display("FAIL b2b_mult busy_cycles=%0d done=%b hi=%h lo=%h want 5 1 %h %h", bc, dn, hi, lo, m_hi, m_lo); end
    // Issue the div in the done cycle; bc==10 proves busy rose at the very next edge.
    do_op(3'd2, 32'd1000, 32'hFFFFFFFD, bc, dn);
    model(3'd2, 32'd1000, 32'hFFFFFFFD, m_hi, m_lo);
    tests++; if (bc !== 10 || dn !== 1'b1 || hi !== m_hi || lo !== m_lo) begin fails++; $display("FAIL b2b_div busy_cycles=%0d done=%b hi=%h lo=%h want 10 1 %h %h", bc, dn, hi, lo, m_hi, m_lo); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_random;
    test_cancel;
    test_start_while_busy;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
